// File: rtl/shift_sched.sv
// Scroll scheduler: turns the divider tick into the banner shift offset (wrap left/right, bounce with dwell, freeze).
// The end/wrap pulse port is named edge_pulse because "edge" is a reserved word in SystemVerilog.
module shift_sched #(
  parameter int unsigned SHIFT_W     = 3,
  parameter int unsigned MAX_SHIFT   = 7,
  parameter int unsigned STEP_TICKS  = 4,
  parameter int unsigned PAUSE_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  output logic [SHIFT_W-1:0] shift,
  output logic               dir,
  output logic               busy,
  output logic               edge_pulse
);

  localparam int unsigned CNT_MAX = (STEP_TICKS > PAUSE_TICKS) ? STEP_TICKS : PAUSE_TICKS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX  = SHIFT_W'(MAX_SHIFT);
  localparam logic [SHIFT_W-1:0] SHIFT_ONE  = SHIFT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;
  typedef enum logic [1:0] {WRAP_L = 2'b00, WRAP_R = 2'b01, BOUNCE = 2'b10, FREEZE = 2'b11} mode_t;

  state_t             state, state_n;
  mode_t              lmode, lmode_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SHIFT_W-1:0] shift_n, bounce_nxt;
  logic               dir_n, busy_n, edge_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lmode      <= WRAP_L;
      cnt        <= '0;
      shift      <= '0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      lmode      <= lmode_n;
      cnt        <= cnt_n;
      shift      <= shift_n;
      dir        <= dir_n;
      busy       <= busy_n;
      edge_pulse <= edge_n;
    end
  end

  assign bounce_nxt = dir ? (shift - SHIFT_ONE) : (shift + SHIFT_ONE);

  // Priority: stop, then start (which swallows a coincident tick), then tick-driven counting.
  always_comb begin
    state_n = state;
    lmode_n = lmode;
    cnt_n   = cnt;
    shift_n = shift;
    dir_n   = dir;
    edge_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (start) begin
      state_n = RUN;
      cnt_n   = '0;
      lmode_n = mode_t'(mode);
      if (mode_t'(mode) == WRAP_R) begin
        shift_n = SHIFT_MAX;
        dir_n   = 1'b1;
      end else begin
        shift_n = '0;
        dir_n   = 1'b0;
      end
    end else if (tick) begin
      case (state)
        RUN: begin
          if (cnt == STEP_LAST) begin
            cnt_n = '0;
            case (lmode)
              WRAP_L: begin
                if (shift == SHIFT_MAX) begin
                  shift_n = '0;
                  edge_n  = 1'b1;
                end else begin
                  shift_n = shift + SHIFT_ONE;
                end
              end
              WRAP_R: begin
                if (shift == '0) begin
                  shift_n = SHIFT_MAX;
                  edge_n  = 1'b1;
                end else begin
                  shift_n = shift - SHIFT_ONE;
                end
              end
              BOUNCE: begin
                shift_n = bounce_nxt;
                if (bounce_nxt == '0 || bounce_nxt == SHIFT_MAX) begin
                  edge_n = 1'b1;
                  dir_n  = ~dir;
                  if (PAUSE_TICKS > 0) state_n = DWELL;
                end
              end
              default: ;
            endcase
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DWELL: begin
          if (cnt == PAUSE_LAST) begin
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: expected shift/edge/dir events are queued with their cycle stamps and matched as the DUT produces them.
module tb_shift_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] shift;
  logic       dir, busy, edge_pulse;

  logic       start0 = 1'b0, stop0 = 1'b0;
  logic [1:0] mode0 = 2'b00;
  logic [2:0] shift0;
  logic       dir0, busy0, edge0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [2:0] shift;
    logic       edg;
    logic       dir;
  } ev_t;
  ev_t        sb[$];
  ev_t        cur;
  logic [2:0] prev = '0;

  shift_sched #(.SHIFT_W(3), .MAX_SHIFT(7), .STEP_TICKS(4), .PAUSE_TICKS(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .mode(mode),
    .shift(shift), .dir(dir), .busy(busy), .edge_pulse(edge_pulse)
  );

  shift_sched #(.SHIFT_W(3), .MAX_SHIFT(7), .STEP_TICKS(4), .PAUSE_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start(start0), .stop(stop0), .mode(mode0),
    .shift(shift0), .dir(dir0), .busy(busy0), .edge_pulse(edge0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push(input int t, input int s, input bit e, input bit d);
    sb.push_back('{cyc: t, shift: 3'(s), edg: e, dir: d});
  endtask

  task automatic run_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_rst(input string tag);
    #1 rst = 1'b1;
    #1;
    check({tag, "_shift"}, 32'(shift), 0);
    check({tag, "_dir"},   32'(dir), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_edge"},  32'(edge_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Every change of shift (or any edge pulse) must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      prev = shift;
    end else if (shift !== prev || edge_pulse) begin
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        check("ev_cycle", 32'(cyc), 32'(cur.cyc));
        check("ev_shift", 32'(shift), 32'(cur.shift));
        check("ev_edge",  32'(edge_pulse), 32'(cur.edg));
        check("ev_dir",   32'(dir), 32'(cur.dir));
      end
      prev = shift;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, e, f, g;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_shift", 32'(shift), 0);
    check("rst_dir",   32'(dir), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_edge",  32'(edge_pulse), 0);
    rst = 1'b0;
    tick = 1'b1;
    @(negedge clk);

    // Wrap-left
    c = cyc; mode = 2'b00; start = 1'b1;
    for (int n = 1; n <= 8; n++) push(c + 1 + 4 * n, n % 8, n == 8, 0);
    @(negedge clk); start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    run_until(c + 33);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("t1_stop_busy", 32'(busy), 0);

    // Wrap-right
    c = cyc; mode = 2'b01; start = 1'b1;
    push(c + 1, 7, 0, 1);
    for (int n = 1; n <= 8; n++) push(c + 1 + 4 * n, (7 - n) & 7, n == 8, 1);
    @(negedge clk); start = 1'b0;
    run_until(c + 33);
    stop = 1'b1; @(negedge clk); stop = 1'b0;

    // Bounce with dwell: 12 cycles between landing on an end and the next step
    c = cyc; mode = 2'b10; start = 1'b1;
    push(c + 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) push(c + 1 + 4 * k, k, k == 7, k == 7);
    for (int j = 1; j <= 7; j++) push(c + 37 + 4 * j, 7 - j, j == 7, j != 7);
    push(c + 77, 1, 0, 0);
    @(negedge clk); start = 1'b0;
    run_until(c + 35);
    check("t3_dwell_busy", 32'(busy), 1);
    run_until(c + 77);
    stop = 1'b1; @(negedge clk); stop = 1'b0;

    // Stop beats start
    c = cyc; mode = 2'b00; start = 1'b1;
    for (int n = 0; n <= 3; n++) push(c + 1 + 4 * n, n, 0, 0);
    @(negedge clk); start = 1'b0;
    run_until(c + 13);
    stop = 1'b1; start = 1'b1;
    @(negedge clk); stop = 1'b0; start = 1'b0;
    check("t4_busy", 32'(busy), 0);
    check("t4_shift", 32'(shift), 3);
    run_until(c + 22);
    check("t4_hold", 32'(shift), 3);
    d = cyc; start = 1'b1;
    push(d + 1, 0, 0, 0);
    push(d + 5, 1, 0, 0);
    @(negedge clk); start = 1'b0;
    check("t4_restart_busy", 32'(busy), 1);
    run_until(d + 6);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("t4_stop2_busy", 32'(busy), 0);
    run_until(d + 12);
    check("t4_hold2", 32'(shift), 1);

    // Freeze for 40 ticks, then asynchronous reset
    e = cyc; mode = 2'b11; start = 1'b1;
    push(e + 1, 0, 0, 0);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 10 == 9) check("t5_freeze_busy", 32'(busy), 1);
    end
    pulse_rst("t5_rst_freeze");
    f = cyc; mode = 2'b01; start = 1'b1;
    push(f + 1, 7, 0, 1);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("t5_pre_shift", 32'(shift), 7);
    pulse_rst("t5_rst_run");

    // PAUSE_TICKS = 0 bounce turns without dwell
    g = cyc; mode0 = 2'b10; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    run_until(g + 25);
    check("t6_shift6", 32'(shift0), 6);
    run_until(g + 28);
    check("t6_shift6_hold", 32'(shift0), 6);
    run_until(g + 29);
    check("t6_shift7", 32'(shift0), 7);
    check("t6_edge7", 32'(edge0), 1);
    check("t6_dir7", 32'(dir0), 1);
    run_until(g + 30);
    check("t6_edge_clear", 32'(edge0), 0);
    run_until(g + 32);
    check("t6_shift7_hold", 32'(shift0), 7);
    run_until(g + 33);
    check("t6_shift6b", 32'(shift0), 6);
    check("t6_edge6b", 32'(edge0), 0);
    stop0 = 1'b1; @(negedge clk); stop0 = 1'b0;
    check("t6_busy", 32'(busy0), 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
